// File: rtl/audio_addr_pkg.sv
// Shared types and constants for the audio address sequencer.
package audio_addr_pkg;

  localparam int unsigned DEFAULT_ADDR_W = 17;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RECORD = 2'd1,
    PLAY   = 2'd2
  } state_e;

endpackage

// File: rtl/audio_address_sequencer.sv
// Walks a memory address through a latched [start, end] region, advancing on
// deserializer strobes while recording and on serializer strobes while playing.
module audio_address_sequencer
  import audio_addr_pkg::*;
#(
  parameter int unsigned ADDR_W       = DEFAULT_ADDR_W,
  parameter bit          LOOP_DEFAULT = 1'b0
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              start_record,
  input  logic              start_play,
  input  logic              stop,
  input  logic              loop_en,
  input  logic [ADDR_W-1:0] start_address,
  input  logic [ADDR_W-1:0] end_address,
  input  logic              des_done,
  input  logic              ser_done,
  output logic [ADDR_W-1:0] address,
  output logic              recording,
  output logic              playing,
  output logic              done,
  output logic              wrapped,
  output logic              err
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   start_q, start_d;
  logic [ADDR_W-1:0]   end_q, end_d;
  logic                loop_q, loop_d;
  logic                done_q, done_d;
  logic                wrapped_q, wrapped_d;
  logic                err_q, err_d;
  logic                recording_q, playing_q;
  logic                start_req;
  logic                advance;

  assign start_req = start_record | start_play;
  assign advance   = ((state_q == RECORD) && des_done) || ((state_q == PLAY) && ser_done);

  // Priority: stop, then start (validated), then strobe advance.
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    start_d   = start_q;
    end_d     = end_q;
    loop_d    = loop_q;
    done_d    = 1'b0;
    wrapped_d = 1'b0;
    err_d     = 1'b0;

    if (stop) begin
      state_d = IDLE;
    end else if (start_req) begin
      if (end_address < start_address) begin
        err_d = 1'b1;
      end else begin
        start_d = start_address;
        end_d   = end_address;
        loop_d  = loop_en;
        addr_d  = start_address;
        state_d = start_record ? RECORD : PLAY;
      end
    end else if (advance) begin
      // End check precedes the increment so the address never passes the end.
      if (addr_q == end_q) begin
        if (loop_q) begin
          addr_d    = start_q;
          wrapped_d = 1'b1;
        end else begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end else begin
        addr_d = addr_q + ADDR_W'(1);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= IDLE;
      addr_q      <= '0;
      start_q     <= '0;
      end_q       <= '0;
      loop_q      <= LOOP_DEFAULT;
      done_q      <= 1'b0;
      wrapped_q   <= 1'b0;
      err_q       <= 1'b0;
      recording_q <= 1'b0;
      playing_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      start_q     <= start_d;
      end_q       <= end_d;
      loop_q      <= loop_d;
      done_q      <= done_d;
      wrapped_q   <= wrapped_d;
      err_q       <= err_d;
      recording_q <= (state_d == RECORD);
      playing_q   <= (state_d == PLAY);
    end
  end

  assign address   = addr_q;
  assign recording = recording_q;
  assign playing   = playing_q;
  assign done      = done_q;
  assign wrapped   = wrapped_q;
  assign err       = err_q;

endmodule

// File: tb/tb_audio_address_sequencer.sv
// Directed scoreboard bench: the driver queues the expected outputs for each
// edge and an independent monitor pops and compares after that edge.
module tb_audio_address_sequencer;

  localparam int unsigned AW = 17;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic          rec;
    logic          play;
    logic          done;
    logic          wrap;
    logic          err;
  } exp_t;

  logic          clock = 1'b0;
  logic          reset;
  logic          start_record, start_play, stop, loop_en;
  logic [AW-1:0] start_address, end_address;
  logic          des_done, ser_done;
  logic [AW-1:0] address;
  logic          recording, playing, done, wrapped, err;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   step   = 0;

  always #5 clock = ~clock;

  audio_address_sequencer #(
    .ADDR_W      (AW),
    .LOOP_DEFAULT(1'b0)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .start_record (start_record),
    .start_play   (start_play),
    .stop         (stop),
    .loop_en      (loop_en),
    .start_address(start_address),
    .end_address  (end_address),
    .des_done     (des_done),
    .ser_done     (ser_done),
    .address      (address),
    .recording    (recording),
    .playing      (playing),
    .done         (done),
    .wrapped      (wrapped),
    .err          (err)
  );

  // Monitor: one expectation per rising edge, sampled 1 time unit later.
  initial begin
    exp_t e;
    exp_t got;
    forever begin
      @(posedge clock);
      #1;
      if (sb_q.size() > 0) begin
        e   = sb_q.pop_front();
        got = '{addr: address, rec: recording, play: playing, done: done, wrap: wrapped,
                err: err};
        checks++;
        if (got !== e) begin
          errors++;
          $display("FAIL step%0d got addr=%h rec=%b play=%b done=%b wrap=%b err=%b want addr=%h rec=%b play=%b done=%b wrap=%b err=%b",
                   step, got.addr, got.rec, got.play, got.done, got.wrap, got.err,
                   e.addr, e.rec, e.play, e.done, e.wrap, e.err);
        end
        step++;
      end
    end
  end

  task automatic clr();
    reset        = 1'b0;
    start_record = 1'b0;
    start_play   = 1'b0;
    stop         = 1'b0;
    des_done     = 1'b0;
    ser_done     = 1'b0;
  endtask

  task automatic tick(input logic [AW-1:0] a, input logic r, input logic p, input logic d,
                      input logic w, input logic e);
    sb_q.push_back('{addr: a, rec: r, play: p, done: d, wrap: w, err: e});
    @(negedge clock);
    clr();
  endtask

  initial begin
    clr();
    loop_en = 1'b0; start_address = '0; end_address = '0;

    reset = 1'b1;                      tick(0, 0, 0, 0, 0, 0);
    reset = 1'b1; des_done = 1'b1;     tick(0, 0, 0, 0, 0, 0);
    des_done = 1'b1; ser_done = 1'b1;  tick(0, 0, 0, 0, 0, 0);

    // Non-looping record 100..103; region inputs change mid-pass.
    start_address = 100; end_address = 103; loop_en = 1'b0;
    start_record = 1'b1;               tick(100, 1, 0, 0, 0, 0);
    start_address = 0; end_address = 200; loop_en = 1'b1;
    des_done = 1'b1;                   tick(101, 1, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(102, 1, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(103, 1, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(103, 0, 0, 1, 0, 0);
    des_done = 1'b1;                   tick(103, 0, 0, 0, 0, 0);

    // Cross-strobe rejection and stop priority over an advance.
    start_address = 10; end_address = 20; loop_en = 1'b0;
    start_record = 1'b1;               tick(10, 1, 0, 0, 0, 0);
    ser_done = 1'b1;                   tick(10, 1, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(11, 1, 0, 0, 0, 0);
    stop = 1'b1; des_done = 1'b1;      tick(11, 0, 0, 0, 0, 0);

    // Looping play 0..2.
    start_address = 0; end_address = 2; loop_en = 1'b1;
    start_play = 1'b1;                 tick(0, 0, 1, 0, 0, 0);
    ser_done = 1'b1;                   tick(1, 0, 1, 0, 0, 0);
    ser_done = 1'b1;                   tick(2, 0, 1, 0, 0, 0);
    ser_done = 1'b1;                   tick(0, 0, 1, 0, 1, 0);
    ser_done = 1'b1;                   tick(1, 0, 1, 0, 0, 0);
    ser_done = 1'b1;                   tick(2, 0, 1, 0, 0, 0);
    des_done = 1'b1;                   tick(2, 0, 1, 0, 0, 0);
    stop = 1'b1;                       tick(2, 0, 0, 0, 0, 0);

    // Priority: stop beats both starts; record beats play.
    start_address = 5; end_address = 9; loop_en = 1'b0;
    start_record = 1'b1; start_play = 1'b1; stop = 1'b1;
                                       tick(2, 0, 0, 0, 0, 0);
    start_record = 1'b1; start_play = 1'b1;
                                       tick(5, 1, 0, 0, 0, 0);

    // Restart mid-pass with a new region, no done pulse.
    start_address = 30; end_address = 31;
    start_play = 1'b1;                 tick(30, 0, 1, 0, 0, 0);

    // Invalid region rejected; running pass keeps going afterwards.
    start_address = 50; end_address = 40;
    start_record = 1'b1;               tick(30, 0, 1, 0, 0, 1);
    ser_done = 1'b1;                   tick(31, 0, 1, 0, 0, 0);
    ser_done = 1'b1;                   tick(31, 0, 0, 1, 0, 0);
    start_play = 1'b1;                 tick(31, 0, 0, 0, 0, 1);

    // Degenerate region, non-looping then looping.
    start_address = 7; end_address = 7; loop_en = 1'b0;
    start_record = 1'b1;               tick(7, 1, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(7, 0, 0, 1, 0, 0);
    loop_en = 1'b1;
    start_play = 1'b1;                 tick(7, 0, 1, 0, 0, 0);
    ser_done = 1'b1;                   tick(7, 0, 1, 0, 1, 0);

    // Top of address space: no overflow past end, then reset mid-pass.
    start_address = 17'h1FFFE; end_address = 17'h1FFFF; loop_en = 1'b0;
    start_record = 1'b1;               tick(17'h1FFFE, 1, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(17'h1FFFF, 1, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(17'h1FFFF, 0, 0, 1, 0, 0);
    start_record = 1'b1;               tick(17'h1FFFE, 1, 0, 0, 0, 0);
    reset = 1'b1; des_done = 1'b1; start_play = 1'b1;
                                       tick(0, 0, 0, 0, 0, 0);
    des_done = 1'b1;                   tick(0, 0, 0, 0, 0, 0);

    // Drain the scoreboard with a bounded wait.
    for (int i = 0; i < 5 && sb_q.size() > 0; i++) @(negedge clock);
    if (sb_q.size() > 0) begin
      errors++;
      $display("FAIL drain got %0d pending want 0", sb_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
